lif_sweep_scheduler: RTL
========================

# lif_sweep_scheduler

Time-multiplexed scheduler that shares one leaky-integrate-and-fire update datapath across `NUM_NEURONS` virtual neurons. It holds per-neuron membrane state and input-current registers. On each `step` request it sweeps all neurons in index order, one update per cycle. Spikes leave as indexed events on a valid/ready stream, which back-pressures the sweep. The block sits between the input switch/stimulus logic and the spike/state outputs of the neuron tile.

## Interface

Parameters:
- `NUM_NEURONS`, default 4: number of virtual neurons; power of two, 2–16.
- `WIDTH`, default 8: membrane state, current and threshold width.
- `THRESH_RST`, default 128: threshold value loaded at reset.

Ports:
- `clk`  in  1  single clock; all state is updated on the rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `step`  in  1  request one full sweep; sampled only in IDLE.
- `busy`  out  1  high while the sweep is in progress.
- `done`  out  1  one-cycle pulse after the last neuron of a sweep is updated.
- `stim_we`  in  1  write enable for a per-neuron current register.
- `stim_idx`  in  log2(NUM_NEURONS)  neuron index for the current write.
- `stim_current`  in  WIDTH  current value to write.
- `thr_we`  in  1  write enable for the threshold.
- `thr_value`  in  WIDTH  new threshold value.
- `spike_valid`  out  1  spike event pending.
- `spike_idx`  out  log2(NUM_NEURONS)  index of the neuron that spiked.
- `spike_ready`  in  1  consumer accepts the event.
- `mon_idx`  in  log2(NUM_NEURONS)  neuron selected for monitoring.
- `mon_state`  out  WIDTH  registered membrane state of neuron `mon_idx`.

## Operation

- Storage: `state[i]` and `cur[i]` for each neuron, plus an active threshold `thr` and a shadow threshold `thr_sh`.
- FSM has two states, IDLE and SWEEP, with an index counter `idx`.
  - IDLE with `step`=1: go to SWEEP, set `idx`=0, copy `thr_sh` into `thr`.
  - IDLE with `step`=0: stay in IDLE.
  - In SWEEP, `step` is ignored.
- Update rule for neuron `idx`, each SWEEP cycle that is not stalled:
  - `fire` = (`state[idx]` >= `thr`).
  - If `fire`: `state[idx]` is set to 0.
  - Otherwise: `state[idx]` is set to min(`cur[idx]` + (`state[idx]` >> 1), 2^WIDTH−1). The sum is computed at WIDTH+1 bits and saturates to WIDTH bits.
- Stall: if `fire`=1, `spike_valid`=1 and `spike_ready`=0, there is no state update and `idx` holds. A non-firing neuron never stalls.
- Advance: after an unstalled update, `idx` increments. If `idx`=NUM_NEURONS−1, the FSM returns to IDLE instead and `done` pulses.
- Spike stream:
  - A firing update sets `spike_valid`=1 and `spike_idx`=`idx` at the same edge.
  - `spike_valid` clears on the edge where `spike_valid` & `spike_ready` is true, unless a new spike is loaded on that same edge; in that case it stays 1 with the new index.
  - `spike_valid` and `spike_idx` are held stable until accepted.
- Stimulus writes:
  - `stim_we` writes `cur[stim_idx]` in any FSM state.
  - If the write targets the neuron being updated in the same cycle, the update uses the old `cur` value and the new value is stored.
- Threshold writes: `thr_we` writes `thr_sh` only. The value takes effect at the next sweep start. If `thr_we` and the sweep start coincide, the new value is used.
- Monitor: `mon_state` <= `state[mon_idx]` every cycle, so it reflects the post-update value one cycle after the update edge.
- Reset (asynchronous, at any time, including mid-sweep):
  - Cleared to 0: all `state[i]`, all `cur[i]`, `idx`, `busy`, `done`, `spike_valid`, `spike_idx` and `mon_state`.
  - FSM goes to IDLE.
  - `thr` = `thr_sh` = `THRESH_RST`.
  - A pending spike is discarded.

## Timing

- `step` sampled high in IDLE at edge E0 → `busy`=1 from E0.
- With no stalls, neuron k updates at edge E0+1+k, and `busy` falls at edge E0+NUM_NEURONS.
- `done`=1 for exactly the one cycle after `busy` falls (registered at the same edge that `busy` falls).
- Each stall cycle adds one cycle to the sweep.
- Minimum sweep-to-sweep period is NUM_NEURONS+1 cycles: `step` held high restarts the sweep in the cycle after `busy` falls.
- Spike latency: `spike_valid` is high in the cycle following the firing update edge. Throughput is one event per cycle when `spike_ready`=1.

## Test plan

- Integrate/fire, N=4, W=8, thr=128, `cur[0]`=100, three `step`s → `state[0]`=100, then 150, then 0. One spike with `spike_idx`=0 occurs on sweep 3. The other neurons stay 0.
- Saturation, `thr_we` 255, `cur[1]`=200 → sweeps give `state[1]`=200, then 255 (not 44), then spike and 0.
- Back-pressure: `cur[0..3]`=200, thr=128, two sweeps, `spike_ready` low for 5 cycles during sweep 2 → neuron 0's event is pending and neuron 1 stalls for 5 cycles. After release, events arrive in order 0,1,2,3, none are lost, and `busy` is extended by the stall count.
- Timing: `step` pulse with no spikes → `busy` high exactly 4 cycles, then `done` one cycle. A `step` while busy is ignored, giving exactly one `done`.
- Collisions: `stim_we` to `idx` during its update cycle → old current is used and the new value appears next sweep. `thr_we` mid-sweep → the current sweep keeps the old threshold.
- Reset mid-sweep with a pending spike (`rst` asserted at idx=2) → all outputs 0 immediately and thr=`THRESH_RST`. A next `step` sweeps from idx 0.

Source files
------------

// File: rtl/lif_sweep_scheduler.sv
// Shared leaky-integrate-and-fire datapath swept across virtual neurons.
// Spikes leave as indexed events on a valid/ready stream that can stall the sweep.
module lif_sweep_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int WIDTH       = 8,
  parameter int THRESH_RST  = 128,
  localparam int IW         = $clog2(NUM_NEURONS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic             busy,
  output logic             done,
  input  logic             stim_we,
  input  logic [IW-1:0]    stim_idx,
  input  logic [WIDTH-1:0] stim_current,
  input  logic             thr_we,
  input  logic [WIDTH-1:0] thr_value,
  output logic             spike_valid,
  output logic [IW-1:0]    spike_idx,
  input  logic             spike_ready,
  input  logic [IW-1:0]    mon_idx,
  output logic [WIDTH-1:0] mon_state
);

  typedef enum logic {IDLE, SWEEP} fsm_e;

  localparam logic [IW-1:0]    LAST = IW'(NUM_NEURONS - 1);
  localparam logic [WIDTH-1:0] TRST = WIDTH'(THRESH_RST);

  fsm_e             fsm_q, fsm_d;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] state_q [NUM_NEURONS];
  logic [WIDTH-1:0] cur_q   [NUM_NEURONS];
  logic [WIDTH-1:0] thr_q, thr_sh_q;

  logic [WIDTH-1:0] st_cur, cur_sel, st_nxt;
  logic [WIDTH:0]   sum;
  logic             fire, stall, upd, last, start;

  always_comb begin
    st_cur  = state_q[idx_q];
    cur_sel = cur_q[idx_q];
    fire    = st_cur >= thr_q;
    sum     = {1'b0, cur_sel} + {2'b0, st_cur[WIDTH-1:1]};
    if (fire)
      st_nxt = '0;
    else if (sum[WIDTH])
      st_nxt = '1;
    else
      st_nxt = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    start = 1'b0;
    upd   = 1'b0;
    stall = 1'b0;
    last  = idx_q == LAST;
    unique case (fsm_q)
      IDLE: begin
        if (step) begin
          start = 1'b1;
          fsm_d = SWEEP;
        end
      end
      SWEEP: begin
        stall = fire & spike_valid & ~spike_ready;
        upd   = ~stall;
        if (upd && last) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign busy = fsm_q == SWEEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      thr_q       <= TRST;
      thr_sh_q    <= TRST;
      done        <= 1'b0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      mon_state   <= '0;
    end else begin
      if (thr_we) thr_sh_q <= thr_value;
      // a threshold written on the start edge is already the one used
      if (start) begin
        idx_q <= '0;
        thr_q <= thr_we ? thr_value : thr_sh_q;
      end else if (upd) begin
        idx_q <= last ? '0 : idx_q + IW'(1);
      end
      done <= upd & last;
      if (upd && fire) begin
        spike_valid <= 1'b1;
        spike_idx   <= idx_q;
      end else if (spike_valid && spike_ready) begin
        spike_valid <= 1'b0;
      end
      mon_state <= state_q[mon_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        state_q[i] <= '0;
        cur_q[i]   <= '0;
      end
    end else begin
      if (upd) state_q[idx_q] <= st_nxt;
      if (stim_we) cur_q[stim_idx] <= stim_current;
    end
  end

endmodule
